// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NREQ_MAX = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning from rPrio,
// pointer advances past the winner on every grant.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic [NREQ-1:0]  iReq,
  output logic [NREQ-1:0]  oGrant,
  output logic [IDX_W-1:0] oGrantIdx,
  output logic             oAny
);
  import regfile_pkg::*;

  logic [IDX_W-1:0] rPrio;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    oGrant    = '0;
    oGrantIdx = '0;
    oAny      = 1'b0;
    sum       = '0;
    idx       = '0;
    if (!iReset) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rPrio} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
        idx = sum[IDX_W-1:0];
        if (!oAny && iReq[idx]) begin
          oAny        = 1'b1;
          oGrant[idx] = 1'b1;
          oGrantIdx   = idx;
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset)
      rPrio <= '0;
    else if (oAny)
      rPrio <= (oGrantIdx == IDX_W'(NREQ-1)) ? '0 : oGrantIdx + IDX_W'(1);
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources.
// Define WB_FWD_EN to bypass the registered write onto the read ports.
module regfile_wb_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic [NREQ-1:0]        iReqValid,
  input  logic [NREQ*ADDR_W-1:0] iReqAddr,
  input  logic [NREQ*DATA_W-1:0] iReqData,
  output logic [NREQ-1:0]        oReqReady,
  output logic                   oWe,
  output logic [ADDR_W-1:0]      oWaddr,
  output logic [DATA_W-1:0]      oWdata,
  input  logic [ADDR_W-1:0]      iRaddr1,
  input  logic [ADDR_W-1:0]      iRaddr2,
  input  logic [DATA_W-1:0]      iRdata1,
  input  logic [DATA_W-1:0]      iRdata2,
  output logic [DATA_W-1:0]      oRdata1,
  output logic [DATA_W-1:0]      oRdata2
);
  import regfile_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grantIdx;
  logic              anyGrant;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .iClk      (iClk),
    .iReset    (iReset),
    .iReq      (iReqValid),
    .oGrant    (grant),
    .oGrantIdx (grantIdx),
    .oAny      (anyGrant)
  );

  assign oReqReady = grant;

  // Grant is one-hot, so an OR of masked lanes is the mux.
  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        selAddr = selAddr | iReqAddr[i*ADDR_W +: ADDR_W];
        selData = selData | iReqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oWe    <= 1'b0;
      oWaddr <= '0;
      oWdata <= '0;
    end else if (anyGrant && selAddr != '0) begin
      oWe    <= 1'b1;
      oWaddr <= selAddr;
      oWdata <= selData;
    end else begin
      oWe    <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  assign oRdata1 = (oWe && oWaddr == iRaddr1 && iRaddr1 != '0) ? oWdata : iRdata1;
  assign oRdata2 = (oWe && oWaddr == iRaddr2 && iRaddr2 != '0) ? oWdata : iRdata2;
`else
  logic unused_raddr;
  assign unused_raddr = ^{iRaddr1, iRaddr2, grantIdx};
  assign oRdata1 = iRdata1;
  assign oRdata2 = iRdata2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with a write scoreboard,
// plus hand sequences for reset and read bypass.
module tb_regfile_wb_arbiter;
  logic        iClk = 1'b0;
  logic        iReset;
  logic [1:0]  iReqValid;
  logic [9:0]  iReqAddr;
  logic [63:0] iReqData;
  logic [1:0]  oReqReady;
  logic        oWe;
  logic [4:0]  oWaddr;
  logic [31:0] oWdata;
  logic [4:0]  iRaddr1, iRaddr2;
  logic [31:0] iRdata1, iRdata2, oRdata1, oRdata2;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) dut (
    .iClk(iClk), .iReset(iReset),
    .iReqValid(iReqValid), .iReqAddr(iReqAddr), .iReqData(iReqData),
    .oReqReady(oReqReady),
    .oWe(oWe), .oWaddr(oWaddr), .oWdata(oWdata),
    .iRaddr1(iRaddr1), .iRaddr2(iRaddr2),
    .iRdata1(iRdata1), .iRdata2(iRdata2),
    .oRdata1(oRdata1), .oRdata2(oRdata2)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t tbl[11];
  wr_t  sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    iReqValid = v;
    iReqAddr  = {a1, a0};
    iReqData  = {d1, d0};
  endtask

  task automatic pop_chk(input int n);
    wr_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d_we", n), {31'd0, oWe}, {31'd0, e.we});
      chk($sformatf("v%0d_waddr", n), {27'd0, oWaddr}, {27'd0, e.addr});
      chk($sformatf("v%0d_wdata", n), oWdata, e.data);
    end
  endtask

  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] exp_fwd;
  wr_t         w;

  initial begin
    //           valid  a0     a1     d0            d1            ready
    tbl[0]  = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        2'b01};
    tbl[1]  = '{2'b11, 5'd5,  5'd6,  32'h55,       32'h66,       2'b10};
    tbl[2]  = '{2'b11, 5'd5,  5'd6,  32'h55,       32'h66,       2'b01};
    tbl[3]  = '{2'b11, 5'd5,  5'd6,  32'h55,       32'h66,       2'b10};
    tbl[4]  = '{2'b10, 5'd0,  5'd0,  32'h0,        32'h1234,     2'b10};
    tbl[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
    tbl[6]  = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h99,       2'b10};
    tbl[7]  = '{2'b01, 5'd9,  5'd0,  32'h77,       32'h0,        2'b01};
    tbl[8]  = '{2'b11, 5'd0,  5'd0,  32'h0,        32'hFF,       2'b10};
    tbl[9]  = '{2'b11, 5'd31, 5'd1,  32'hFFFFFFFF, 32'h1,        2'b01};
    tbl[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};

    iReset = 1'b1;
    iRaddr1 = '0; iRaddr2 = '0; iRdata1 = '0; iRdata2 = '0;
    drive(2'b11, 5'd3, 32'h1, 5'd4, 32'h2);

    // Reset: no grants even with valid requests pending
    for (int c = 0; c < 2; c++) begin
      @(negedge iClk);
      chk("rst_ready", {30'd0, oReqReady}, 32'd0);
    end
    chk("rst_we", {31'd0, oWe}, 32'd0);
    chk("rst_waddr", {27'd0, oWaddr}, 32'd0);
    chk("rst_wdata", oWdata, 32'd0);
    iReset = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      chk("idle_ready", {30'd0, oReqReady}, 32'd0);
      chk("idle_we", {31'd0, oWe}, 32'd0);
      chk("idle_waddr", {27'd0, oWaddr}, 32'd0);
      chk("idle_wdata", oWdata, 32'd0);
    end

    // Table: ready checked same cycle, expected write queued for next edge
    m_addr = '0;
    m_data = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge iClk);
      if (i > 0) pop_chk(i - 1);
      drive(tbl[i].valid, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("v%0d_ready", i), {30'd0, oReqReady}, {30'd0, tbl[i].exp_ready});
      w.we = 1'b0;
      if (tbl[i].exp_ready[0] && tbl[i].a0 != 0) begin
        w.we = 1'b1; m_addr = tbl[i].a0; m_data = tbl[i].d0;
      end else if (tbl[i].exp_ready[1] && tbl[i].a1 != 0) begin
        w.we = 1'b1; m_addr = tbl[i].a1; m_data = tbl[i].d1;
      end
      w.addr = m_addr;
      w.data = m_data;
      sbq.push_back(w);
    end
    @(negedge iClk);
    pop_chk(10);

    // Reset the cycle after a grant: write dropped, pointer back to 0
    drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
    #1 chk("pre_rst_ready", {30'd0, oReqReady}, 32'd1);
    @(negedge iClk);
    chk("pre_rst_we", {31'd0, oWe}, 32'd1);
    chk("pre_rst_waddr", {27'd0, oWaddr}, 32'd4);
    iReset = 1'b1;
    drive(2'b11, 5'd4, 32'h44, 5'd8, 32'h88);
    #1 chk("mid_rst_ready", {30'd0, oReqReady}, 32'd0);
    @(negedge iClk);
    chk("post_rst_we", {31'd0, oWe}, 32'd0);
    chk("post_rst_waddr", {27'd0, oWaddr}, 32'd0);
    chk("post_rst_wdata", oWdata, 32'd0);
    iReset = 1'b0;
    #1 chk("post_rst_ready", {30'd0, oReqReady}, 32'd1);
    @(negedge iClk);
    chk("post_rst_w_we", {31'd0, oWe}, 32'd1);
    chk("post_rst_w_addr", {27'd0, oWaddr}, 32'd4);
    drive(2'b01, 5'd7, 32'hA5, 5'd0, 32'h0);
    #1 chk("fwd_ready", {30'd0, oReqReady}, 32'd1);

    // Read bypass of the registered write
    @(negedge iClk);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    iRaddr1 = 5'd7; iRdata1 = 32'h0;
    iRaddr2 = 5'd0; iRdata2 = 32'h1111;
    #1;
    chk("fwd_we", {31'd0, oWe}, 32'd1);
    chk("fwd_waddr", {27'd0, oWaddr}, 32'd7);
`ifdef WB_FWD_EN
    exp_fwd = 32'hA5;
`else
    exp_fwd = 32'h0;
`endif
    chk("fwd_rdata1", oRdata1, exp_fwd);
    chk("fwd_rdata2_x0", oRdata2, 32'h1111);
    iRaddr2 = 5'd7; iRdata2 = 32'h2222;
`ifdef WB_FWD_EN
    exp_fwd = 32'hA5;
`else
    exp_fwd = 32'h2222;
`endif
    #1 chk("fwd_rdata2", oRdata2, exp_fwd);
    @(negedge iClk);
    chk("nofwd_rdata1", oRdata1, 32'h0);
    chk("nofwd_rdata2", oRdata2, 32'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
